ascii_to_num_parser: RTL and testbench
======================================

// Module: ascii_to_num_parser
// PURPOSE
//  Streaming ASCII-decimal to binary converter; inverse direction of the number-to-ASCII display path.
//  Accepts one ASCII char per handshake (keypad/UART front-end) and accumulates a decimal value.
//  On terminator, presents the binary value plus a status code to the pump set-point logic.
// PARAMETERS
//  NUM_W      17      width of num_out; matches the 17-bit fuel quantity bus
//  MAX_DIGITS 6       maximum digits accepted per entry, leading zeros included
//  MAX_VALUE  131071  largest legal result; anything greater is an overflow
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_char    in   8      ASCII character
//  in_valid   in   1      in_char valid
//  in_ready   out  1      parser can take a char this cycle
//  num_out    out  NUM_W  parsed value; 0 when err_code!=0
//  err_code   out  2      00 ok, 01 empty, 10 bad char, 11 overflow/too many digits
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  busy       out  1      high in ACCUM or ERR
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, num_out=0, err_code=0, busy=0; accumulator and digit count cleared.
//  A char is consumed on the clk edge where in_valid && in_ready. Exactly one char per consume.
//  FSM states: IDLE, ACCUM, ERR, DONE. in_ready=1 in IDLE/ACCUM/ERR and 0 in DONE.
//  IDLE:
//   - space (0x20): ignored.
//   - digit '0'-'9': acc=digit, cnt=1, go to ACCUM.
//   - terminator CR (0x0D) or '#' (0x23): err=01, go to DONE.
//   - ESC (0x1B): stay in IDLE.
//   - any other char: go to ERR with code 10.
//  ACCUM:
//   - digit: acc = acc*10 + digit, computed at NUM_W+4 bits with no truncation; cnt+1.
//   - cnt would exceed MAX_DIGITS, or new acc > MAX_VALUE: go to ERR with code 11.
//   - terminator: num_out=acc, err=00, go to DONE.
//   - ESC: clear acc and cnt, go to IDLE.
//   - other char (space included): go to ERR with code 10.
//  ERR:
//   - Chars are discarded. The first error code is latched and never overwritten.
//   - terminator: num_out=0, err=latched code, go to DONE.
//   - ESC: go to IDLE with code cleared.
//  DONE:
//   - out_valid=1; num_out and err_code are stable.
//   - When out_ready is high: go to IDLE next cycle, out_valid drops, acc and cnt cleared.
//  Latency: terminator accepted on edge N gives out_valid=1 from edge N; registered, no combinational in->out path.
//  out_valid && out_ready in the same cycle as in_valid: the char is not consumed, because in_ready=0 in DONE.
//  Boundary: "131071"+CR gives 131071/00. "131072" overflows on the 6th digit. "0000000" gives 11 on the 7th digit.
//  rst_n low mid-entry or in DONE: all state is discarded on that edge with no partial output; reset has priority over all inputs.
// CONFIGURATION
//  ASCII_BACKSPACE_EN defined:
//   - BS (0x08) in ACCUM: acc = acc/10, cnt-1.
//   - If cnt becomes 0, go to IDLE.
//   - BS in IDLE is ignored. BS in ERR is discarded.
//  ASCII_BACKSPACE_EN undefined: BS is an ordinary bad char (code 10 from IDLE/ACCUM).
// STRUCTURE
//  Package ascii_num_pkg holds:
//   - ASCII constants CHAR_0, CHAR_9, CHAR_CR, CHAR_HASH, CHAR_SP, CHAR_ESC, CHAR_BS.
//   - err_code localparams ERR_OK, ERR_EMPTY, ERR_BADCHAR, ERR_OVF.
//   - FSM state encodings.
//  Sub-module ascii_char_classify (combinational): maps in_char to {is_digit, digit[3:0], is_term, is_esc, is_bs, is_space}.
//  FSM, accumulator and output registers stay in this module.
// TESTING
//  "1","2","5","0",CR, out_ready=1 -> out_valid one cycle, num_out=1250, err=00; back to IDLE.
//  " "," ","7","#" -> num_out=7, err=00. CR alone -> num_out=0, err=01.
//  "4","A","5",CR -> err=10, num_out=0; '5' is consumed but not accumulated.
//  "131072",CR -> err=11. "131071",CR -> 131071/00. "1234567",CR -> err=11.
//  Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_valid and num_out stable, no char lost.
//  "98", then rst_n=0 for one cycle, then "3",CR -> 3/00. With ASCII_BACKSPACE_EN: "98",BS,"3",CR -> 93/00.

Source files
------------

// File: rtl/ascii_num_pkg.sv
// Shared ASCII constants, error codes and FSM states for the ASCII-decimal parser.
package ascii_num_pkg;

    localparam int DEF_NUM_W      = 17;
    localparam int DEF_MAX_DIGITS = 6;
    localparam int DEF_MAX_VALUE  = 131071;

    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_9    = 8'h39;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_HASH = 8'h23;
    localparam logic [7:0] CHAR_SP   = 8'h20;
    localparam logic [7:0] CHAR_ESC  = 8'h1B;
    localparam logic [7:0] CHAR_BS   = 8'h08;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_EMPTY   = 2'b01;
    localparam logic [1:0] ERR_BADCHAR = 2'b10;
    localparam logic [1:0] ERR_OVF     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ERR   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ascii_char_classify.sv
// Combinational classifier: splits an ASCII byte into the character classes the parser FSM acts on.
module ascii_char_classify
    import ascii_num_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_isDigit,
    output logic [3:0] o_digit,
    output logic       o_isTerm,
    output logic       o_isEsc,
    output logic       o_isBs,
    output logic       o_isSpace
);

    // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
    assign o_isDigit = (i_char >= CHAR_0) && (i_char <= CHAR_9);
    assign o_digit   = o_isDigit ? i_char[3:0] : 4'd0;
    assign o_isTerm  = (i_char == CHAR_CR) || (i_char == CHAR_HASH);
    assign o_isEsc   = (i_char == CHAR_ESC);
    assign o_isBs    = (i_char == CHAR_BS);
    assign o_isSpace = (i_char == CHAR_SP);

endmodule

// File: rtl/ascii_to_num_parser.sv
// Streaming ASCII-decimal to binary parser with ok/empty/bad-char/overflow status.
// Optional backspace editing is enabled by defining ASCII_BACKSPACE_EN.
module ascii_to_num_parser
    import ascii_num_pkg::*;
#(
    parameter int NUM_W      = DEF_NUM_W,
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int MAX_VALUE  = DEF_MAX_VALUE
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_char,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NUM_W-1:0] num_out,
    output logic [1:0]       err_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int ACC_W = NUM_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

`ifdef ASCII_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    state_t             r_state;
    logic [NUM_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_errLatch;
    logic [NUM_W-1:0]   r_numOut;
    logic [1:0]         r_errOut;

    state_t             w_nextState;
    logic [NUM_W-1:0]   w_nextAcc;
    logic [CNT_W-1:0]   w_nextCnt;
    logic [1:0]         w_nextErrLatch;
    logic [NUM_W-1:0]   w_nextNumOut;
    logic [1:0]         w_nextErrOut;

    logic               w_isDigit;
    logic [3:0]         w_digit;
    logic               w_isTerm;
    logic               w_isEsc;
    logic               w_isBs;
    logic               w_isSpace;
    logic [ACC_W-1:0]   w_accWide;
    logic               w_overflow;

    ascii_char_classify u_classify (
        .i_char    (in_char),
        .o_isDigit (w_isDigit),
        .o_digit   (w_digit),
        .o_isTerm  (w_isTerm),
        .o_isEsc   (w_isEsc),
        .o_isBs    (w_isBs),
        .o_isSpace (w_isSpace)
    );

    // Wide enough that acc*10+9 never wraps, so the range check sees the true value
    assign w_accWide  = ACC_W'(r_acc) * ACC_W'(10) + ACC_W'(w_digit);
    assign w_overflow = (r_cnt >= CNT_W'(MAX_DIGITS)) || (w_accWide > ACC_W'(MAX_VALUE));

    assign in_ready  = (r_state != ST_DONE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_ACCUM) || (r_state == ST_ERR);
    assign num_out   = r_numOut;
    assign err_code  = r_errOut;

    always_comb begin
        w_nextState    = r_state;
        w_nextAcc      = r_acc;
        w_nextCnt      = r_cnt;
        w_nextErrLatch = r_errLatch;
        w_nextNumOut   = r_numOut;
        w_nextErrOut   = r_errOut;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_isDigit) begin
                        w_nextAcc   = NUM_W'(w_digit);
                        w_nextCnt   = CNT_W'(1);
                        w_nextState = ST_ACCUM;
                    end else if (w_isTerm) begin
                        w_nextNumOut = '0;
                        w_nextErrOut = ERR_EMPTY;
                        w_nextState  = ST_DONE;
                    end else if (w_isSpace || w_isEsc || (BS_EN && w_isBs)) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextErrLatch = ERR_BADCHAR;
                        w_nextState    = ST_ERR;
                    end
                end
            end

            ST_ACCUM: begin
                if (in_valid) begin
                    if (w_isDigit) begin
                        if (w_overflow) begin
                            w_nextErrLatch = ERR_OVF;
                            w_nextState    = ST_ERR;
                        end else begin
                            w_nextAcc = w_accWide[NUM_W-1:0];
                            w_nextCnt = r_cnt + CNT_W'(1);
                        end
                    end else if (w_isTerm) begin
                        w_nextNumOut = r_acc;
                        w_nextErrOut = ERR_OK;
                        w_nextState  = ST_DONE;
                    end else if (w_isEsc) begin
                        w_nextAcc   = '0;
                        w_nextCnt   = '0;
                        w_nextState = ST_IDLE;
                    end else if (BS_EN && w_isBs) begin
                        w_nextAcc = r_acc / NUM_W'(10);
                        w_nextCnt = r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            w_nextState = ST_IDLE;
                        end
                    end else begin
                        w_nextErrLatch = ERR_BADCHAR;
                        w_nextState    = ST_ERR;
                    end
                end
            end

            // Everything but terminator/ESC is swallowed; the first error code sticks
            ST_ERR: begin
                if (in_valid) begin
                    if (w_isTerm) begin
                        w_nextNumOut = '0;
                        w_nextErrOut = r_errLatch;
                        w_nextState  = ST_DONE;
                    end else if (w_isEsc) begin
                        w_nextAcc      = '0;
                        w_nextCnt      = '0;
                        w_nextErrLatch = ERR_OK;
                        w_nextState    = ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    w_nextAcc      = '0;
                    w_nextCnt      = '0;
                    w_nextErrLatch = ERR_OK;
                    w_nextNumOut   = '0;
                    w_nextErrOut   = ERR_OK;
                    w_nextState    = ST_IDLE;
                end
            end

            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_errLatch <= ERR_OK;
            r_numOut   <= '0;
            r_errOut   <= ERR_OK;
        end else begin
            r_state    <= w_nextState;
            r_acc      <= w_nextAcc;
            r_cnt      <= w_nextCnt;
            r_errLatch <= w_nextErrLatch;
            r_numOut   <= w_nextNumOut;
            r_errOut   <= w_nextErrOut;
        end
    end

endmodule

// File: tb/tb_ascii_to_num_parser.sv
// Self-checking bench for ascii_to_num_parser: directed entries plus random entries against a string-level model.
module tb_ascii_to_num_parser;

    typedef logic [7:0] chr_t;
    typedef chr_t chrq_t[$];

    localparam int   MAX_DIGITS = 6;
    localparam int   MAX_VALUE  = 131071;
    localparam chr_t K_CR   = 8'h0D;
    localparam chr_t K_HASH = 8'h23;
    localparam chr_t K_SP   = 8'h20;
    localparam chr_t K_ESC  = 8'h1B;
    localparam chr_t K_BS   = 8'h08;

`ifdef ASCII_BACKSPACE_EN
    localparam bit TB_BS = 1'b1;
`else
    localparam bit TB_BS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] num_out;
    logic [1:0]  err_code;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ascii_to_num_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_char   (in_char),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_out   (num_out),
        .err_code  (err_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Entry-level model: walks the typed characters and decides the outcome from the text alone
    function automatic void refParse(input chrq_t q, output int expNum, output int expErr);
        int  val = 0;
        int  nd = 0;
        int  err = 0;
        bit  started = 1'b0;
        foreach (q[i]) begin
            chr_t c = q[i];
            if (c == K_ESC) begin
                val = 0; nd = 0; err = 0; started = 1'b0;
            end else if (err != 0) begin
                err = err;
            end else if (c >= 8'h30 && c <= 8'h39) begin
                int d = int'(c) - 48;
                if (!started) begin
                    started = 1'b1; val = d; nd = 1;
                end else if (nd + 1 > MAX_DIGITS || val * 10 + d > MAX_VALUE) begin
                    err = 3;
                end else begin
                    val = val * 10 + d; nd++;
                end
            end else if (c == K_SP && !started) begin
                val = val;
            end else if (c == K_BS && TB_BS) begin
                if (started) begin
                    val = val / 10; nd--;
                    if (nd == 0) started = 1'b0;
                end
            end else begin
                err = 2;
            end
        end
        if (err != 0) begin
            expNum = 0; expErr = err;
        end else if (!started) begin
            expNum = 0; expErr = 1;
        end else begin
            expNum = val; expErr = 0;
        end
    endfunction

    function automatic chrq_t mkq(input string s);
        chrq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(chr_t'(s[i]));
        return q;
    endfunction

    // Drives one character and holds it until the parser consumes it on a clock edge
    task automatic applyStimulus(input chr_t c);
        int guard = 0;
        in_char  = c;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) checkOutput("readyTimeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic runEntry(input string tag, input chrq_t q, input chr_t term, input int holdCycles,
                            input bit useConst, input int cNum, input int cErr);
        int eNum, eErr;
        refParse(q, eNum, eErr);
        foreach (q[i]) applyStimulus(q[i]);
        applyStimulus(term);
        checkOutput({tag, ".valid"}, int'(out_valid), 1);
        checkOutput({tag, ".num"}, int'(num_out), eNum);
        checkOutput({tag, ".err"}, int'(err_code), eErr);
        if (useConst) begin
            checkOutput({tag, ".numConst"}, int'(num_out), cNum);
            checkOutput({tag, ".errConst"}, int'(err_code), cErr);
        end
        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".holdValid"}, int'(out_valid), 1);
            checkOutput({tag, ".holdNum"}, int'(num_out), eNum);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, ".drop"}, int'(out_valid), 0);
        checkOutput({tag, ".readyBack"}, int'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        chrq_t q;
        rst_n     = 1'b0;
        in_char   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.inReady", int'(in_ready), 1);
        checkOutput("rst.outValid", int'(out_valid), 0);
        checkOutput("rst.num", int'(num_out), 0);
        checkOutput("rst.err", int'(err_code), 0);
        checkOutput("rst.busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runEntry("d1250", mkq("1250"), K_CR, 0, 1'b1, 1250, 0);
        runEntry("dSp7", mkq("  7"), K_HASH, 0, 1'b1, 7, 0);
        runEntry("dEmpty", mkq(""), K_CR, 0, 1'b1, 0, 1);
        runEntry("dBad", mkq("4A5"), K_CR, 0, 1'b1, 0, 2);
        runEntry("dOvf", mkq("131072"), K_CR, 0, 1'b1, 0, 3);
        runEntry("dMax", mkq("131071"), K_CR, 0, 1'b1, 131071, 0);
        runEntry("dLong", mkq("1234567"), K_CR, 0, 1'b1, 0, 3);
        runEntry("dZeros", mkq("0000000"), K_CR, 0, 1'b1, 0, 3);
        runEntry("dZeros6", mkq("000042"), K_CR, 0, 1'b1, 42, 0);
        runEntry("dTrailSp", mkq("12 "), K_CR, 0, 1'b1, 0, 2);

        applyStimulus(8'h31);
        checkOutput("accum.busy", int'(busy), 1);
        applyStimulus(8'h5A);
        checkOutput("err.busy", int'(busy), 1);
        applyStimulus(K_ESC);
        checkOutput("esc.busy", int'(busy), 0);
        runEntry("dAfterEsc", mkq("8"), K_CR, 0, 1'b1, 8, 0);

        q = mkq("98");
        q.push_back(K_BS);
        q.push_back(8'h33);
        runEntry("dBs", q, K_CR, 0, 1'b1, TB_BS ? 93 : 0, TB_BS ? 0 : 2);

        // Result held while a character waits upstream; it must be taken only after release
        applyStimulus(8'h34);
        applyStimulus(8'h32);
        applyStimulus(K_CR);
        in_char  = 8'h35;
        in_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            checkOutput("hold.inReady", int'(in_ready), 0);
            checkOutput("hold.valid", int'(out_valid), 1);
            checkOutput("hold.num", int'(num_out), 42);
            checkOutput("hold.err", int'(err_code), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("hold.release", int'(out_valid), 0);
        checkOutput("hold.noConsume", int'(busy), 0);
        runEntry("hold.kept", mkq("5"), K_CR, 0, 1'b1, 5, 0);

        applyStimulus(8'h39);
        applyStimulus(8'h38);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midRst.busy", int'(busy), 0);
        checkOutput("midRst.valid", int'(out_valid), 0);
        runEntry("midRst", mkq("3"), K_CR, 0, 1'b1, 3, 0);

        applyStimulus(8'h37);
        applyStimulus(K_CR);
        checkOutput("doneRst.pre", int'(out_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("doneRst.valid", int'(out_valid), 0);
        checkOutput("doneRst.num", int'(num_out), 0);
        checkOutput("doneRst.inReady", int'(in_ready), 1);

        for (int e = 0; e < 60; e++) begin
            chrq_t rq;
            int len = $urandom_range(0, 8);
            for (int k = 0; k < len; k++) begin
                int sel = $urandom_range(0, 99);
                chr_t c;
                if (sel < 60)      c = chr_t'(8'h30 + $urandom_range(0, 9));
                else if (sel < 70) c = K_SP;
                else if (sel < 74) c = K_ESC;
                else if (sel < 80) c = K_BS;
                else begin
                    c = chr_t'($urandom_range(0, 255));
                    while (c == K_CR || c == K_HASH) c = chr_t'($urandom_range(0, 255));
                end
                rq.push_back(c);
            end
            runEntry($sformatf("rnd%0d", e), rq, ($urandom_range(0, 1) == 0) ? K_CR : K_HASH,
                     $urandom_range(0, 3), 1'b0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
